// File: rtl/branch_res_pred.sv
// Branch resolution unit with a direct-mapped BTB and saturating-counter direction predictor.
// Lookup is combinational; resolution results and table updates are registered together.

package rv32i_types_pkg;
  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_t;
endpackage

module branch_res_pred
  import rv32i_types_pkg::*;
#(
  parameter int NENTRIES = 16,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   pred_pc,
  output logic          pred_taken,
  output logic [31:0]   pred_target,
  input  logic          res_valid,
  input  logic [31:0]   res_pc,
  input  logic [31:0]   rs1_data,
  input  logic [31:0]   rs2_data,
  input  logic [12:0]   imm_sb,
  input  branch_t       branch_type,
  input  logic          res_pred_taken,
  input  logic [31:0]   res_pred_target,
  output logic          out_valid,
  output logic          branch_taken,
  output logic [31:0]   branch_addr,
  output logic          mispredict
);

  localparam int IDX_BITS = $clog2(NENTRIES);
  localparam int TAG_LSB  = IDX_BITS + 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1'b1);
  localparam int unsigned CTR_WEAK_INT = 32'd1 << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_WEAK_INT[CTR_BITS-1:0];

  logic                valid_r  [NENTRIES];
  logic [TAG_BITS-1:0] tag_r    [NENTRIES];
  logic [31:0]         target_r [NENTRIES];
  logic [CTR_BITS-1:0] ctr_r    [NENTRIES];

  logic                out_valid_r;
  logic                branch_taken_r;
  logic [31:0]         branch_addr_r;
  logic                mispredict_r;

  logic [IDX_BITS-1:0] pred_idx_s;
  logic [TAG_BITS-1:0] pred_tag_s;
  logic                pred_hit_s;
  logic [IDX_BITS-1:0] res_idx_s;
  logic [TAG_BITS-1:0] res_tag_s;
  logic                res_hit_s;
  logic                eq_s;
  logic                lt_s;
  logic                ltu_s;
  logic                taken_s;
  logic [31:0]         target_s;
  logic [31:0]         next_addr_s;
  logic                mispredict_s;
  logic [CTR_BITS-1:0] ctr_next_s;
  logic                unused_s;

  // Only the index and tag fields of the PCs feed the table.
  assign unused_s = ^{pred_pc, res_pc};

  assign pred_idx_s = pred_pc[TAG_LSB-1:2];
  assign pred_tag_s = pred_pc[TAG_LSB+TAG_BITS-1:TAG_LSB];
  assign res_idx_s  = res_pc[TAG_LSB-1:2];
  assign res_tag_s  = res_pc[TAG_LSB+TAG_BITS-1:TAG_LSB];

  // Fetch-side lookup; reads pre-update state, so no bypass from a same-cycle update.
  always_comb begin
    pred_hit_s  = valid_r[pred_idx_s] && (tag_r[pred_idx_s] == pred_tag_s);
    pred_taken  = pred_hit_s & ctr_r[pred_idx_s][CTR_BITS-1];
    pred_target = pred_pc + 32'd4;
    if (pred_taken) begin
      pred_target = target_r[pred_idx_s];
    end else begin
      pred_target = pred_pc + 32'd4;
    end
  end

  // Resolve branch direction, target and misprediction from the operands.
  always_comb begin
    eq_s     = (rs1_data == rs2_data);
    lt_s     = ($signed(rs1_data) < $signed(rs2_data));
    ltu_s    = (rs1_data < rs2_data);
    taken_s  = 1'b0;
    case (branch_type)
      BEQ:     taken_s = eq_s;
      BNE:     taken_s = ~eq_s;
      BLT:     taken_s = lt_s;
      BGE:     taken_s = ~lt_s;
      BLTU:    taken_s = ltu_s;
      BGEU:    taken_s = ~ltu_s;
      default: taken_s = 1'b0;
    endcase
    target_s     = res_pc + {{19{imm_sb[12]}}, imm_sb};
    next_addr_s  = taken_s ? target_s : (res_pc + 32'd4);
    mispredict_s = (taken_s != res_pred_taken) |
                   (taken_s & (res_pred_target != target_s));
  end

  // Next counter value for the resolved entry: saturating on a hit, weakly taken on allocation.
  always_comb begin
    res_hit_s  = valid_r[res_idx_s] && (tag_r[res_idx_s] == res_tag_s);
    ctr_next_s = CTR_WEAK;
    if (res_hit_s) begin
      if (taken_s) begin
        ctr_next_s = (ctr_r[res_idx_s] == CTR_MAX) ? CTR_MAX : ctr_r[res_idx_s] + CTR_ONE;
      end else begin
        ctr_next_s = (ctr_r[res_idx_s] == CTR_ZERO) ? CTR_ZERO : ctr_r[res_idx_s] - CTR_ONE;
      end
    end else begin
      ctr_next_s = CTR_WEAK;
    end
  end

  // Register the resolution result and update the predictor table on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_r    <= 1'b0;
      branch_taken_r <= 1'b0;
      branch_addr_r  <= 32'd0;
      mispredict_r   <= 1'b0;
      for (int i = 0; i < NENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        ctr_r[i]   <= CTR_ZERO;
      end
    end else begin
      out_valid_r <= res_valid;
      if (res_valid) begin
        branch_taken_r <= taken_s;
        branch_addr_r  <= next_addr_s;
        mispredict_r   <= mispredict_s;
        if (res_hit_s) begin
          ctr_r[res_idx_s] <= ctr_next_s;
          if (taken_s) begin
            target_r[res_idx_s] <= target_s;
          end
        end else if (taken_s) begin
          // Direct-mapped: an aliasing branch simply takes over the slot.
          valid_r[res_idx_s]  <= 1'b1;
          tag_r[res_idx_s]    <= res_tag_s;
          target_r[res_idx_s] <= target_s;
          ctr_r[res_idx_s]    <= ctr_next_s;
        end
      end
    end
  end

  assign out_valid    = out_valid_r;
  assign branch_taken = branch_taken_r;
  assign branch_addr  = branch_addr_r;
  assign mispredict   = mispredict_r;

endmodule

// File: tb/tb_branch_res_pred.sv
// Self-checking bench for branch_res_pred: vector table through a scoreboard,
// plus hand-written sequences for counter saturation, aliasing, hold and reset.

module tb_branch_res_pred;
  import rv32i_types_pkg::*;

  typedef struct {
    branch_t     bt;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [12:0] imm;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_taken;
    logic [31:0] e_addr;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [31:0] addr;
    logic        mis;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] pred_pc = 32'd0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = 32'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [12:0] imm_sb = 13'd0;
  branch_t     branch_type = BEQ;
  logic        res_pred_taken = 1'b0;
  logic [31:0] res_pred_target = 32'd0;
  logic        out_valid;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        mispredict;

  int tests  = 0;
  int failed = 0;
  exp_t sb_q[$];
  vec_t vecs[14];

  branch_res_pred dut (
    .CLK(CLK), .RST(RST),
    .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm_sb(imm_sb), .branch_type(branch_type),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .out_valid(out_valid), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .mispredict(mispredict)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(branch_t bt, logic [31:0] a, logic [31:0] b, logic [31:0] pc,
                              logic [12:0] imm, logic pt, logic [31:0] ptgt,
                              logic et, logic [31:0] ea, logic em);
    vec_t v;
    v.bt = bt; v.rs1 = a; v.rs2 = b; v.pc = pc; v.imm = imm; v.pt = pt; v.ptgt = ptgt;
    v.e_taken = et; v.e_addr = ea; v.e_mis = em;
    return v;
  endfunction

  // Drive one resolution at a falling edge and record its expected result.
  task automatic issue(input vec_t v);
    exp_t e;
    @(negedge CLK);
    res_valid = 1'b1; branch_type = v.bt; rs1_data = v.rs1; rs2_data = v.rs2;
    res_pc = v.pc; imm_sb = v.imm; res_pred_taken = v.pt; res_pred_target = v.ptgt;
    e.taken = v.e_taken; e.addr = v.e_addr; e.mis = v.e_mis;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge CLK);
    res_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; res_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc,
                      input logic et, input logic [31:0] etgt);
    pred_pc = pc;
    #1;
    check({name, " pred_taken"}, {31'd0, pred_taken}, {31'd0, et});
    check({name, " pred_target"}, pred_target, etgt);
  endtask

  // Scoreboard monitor: every registered result pops one expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected out_valid: got 1 expected 0");
      end else begin
        e = sb_q.pop_front();
        check("branch_taken", {31'd0, branch_taken}, {31'd0, e.taken});
        check("branch_addr", branch_addr, e.addr);
        check("mispredict", {31'd0, mispredict}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    vecs[0]  = mk(BEQ,  32'd5, 32'd5, 32'h100, 13'h010, 1'b0, 32'h0,   1'b1, 32'h110, 1'b1);
    vecs[1]  = mk(BNE,  32'd5, 32'd5, 32'h300, 13'h020, 1'b0, 32'h0,   1'b0, 32'h304, 1'b0);
    vecs[2]  = mk(BNE,  32'd1, 32'd2, 32'h300, 13'h020, 1'b1, 32'h320, 1'b1, 32'h320, 1'b0);
    vecs[3]  = mk(BLT,  32'hFFFFFFFF, 32'd1, 32'h400, 13'h008, 1'b0, 32'h0, 1'b1, 32'h408, 1'b1);
    vecs[4]  = mk(BLTU, 32'hFFFFFFFF, 32'd1, 32'h400, 13'h008, 1'b0, 32'h0, 1'b0, 32'h404, 1'b0);
    vecs[5]  = mk(BGE,  32'd1, 32'hFFFFFFFF, 32'h500, 13'h00C, 1'b1, 32'h50C, 1'b1, 32'h50C, 1'b0);
    vecs[6]  = mk(BGEU, 32'd1, 32'hFFFFFFFF, 32'h500, 13'h00C, 1'b1, 32'h50C, 1'b0, 32'h504, 1'b1);
    vecs[7]  = mk(BEQ,  32'd0, 32'd0, 32'h200, 13'h1FF0, 1'b1, 32'h1F0, 1'b1, 32'h1F0, 1'b0);
    vecs[8]  = mk(BEQ,  32'd7, 32'd7, 32'h600, 13'h040, 1'b1, 32'h644, 1'b1, 32'h640, 1'b1);
    vecs[9]  = mk(BNE,  32'd3, 32'd3, 32'h700, 13'h004, 1'b1, 32'h704, 1'b0, 32'h704, 1'b1);
    vecs[10] = mk(BGE,  32'd0, 32'd5, 32'h800, 13'h100, 1'b0, 32'hDEAD, 1'b0, 32'h804, 1'b0);
    vecs[11] = mk(BEQ,  32'd9, 32'd9, 32'hFFFFFFF0, 13'h020, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1);
    vecs[12] = mk(BLT,  32'd5, 32'd5, 32'h900, 13'h010, 1'b0, 32'h0,   1'b0, 32'h904, 1'b0);
    vecs[13] = mk(BGEU, 32'd5, 32'd5, 32'h900, 13'h0FFE, 1'b0, 32'h0,  1'b1, 32'h18FE, 1'b1);

    // Reset state and cold lookup.
    repeat (2) @(negedge CLK);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset branch_taken", {31'd0, branch_taken}, 32'd0);
    check("reset branch_addr", branch_addr, 32'd0);
    check("reset mispredict", {31'd0, mispredict}, 32'd0);
    look("cold 0x100", 32'h100, 1'b0, 32'h104);
    RST = 1'b0;

    // Back-to-back resolution vectors.
    for (int i = 0; i < 14; i++) issue(vecs[i]);
    idle();

    // Allocation, with a same-cycle lookup seeing the pre-update table.
    do_reset();
    issue(vecs[0]);
    look("same-cycle 0x100", 32'h100, 1'b0, 32'h104);
    idle();
    look("alloc 0x100", 32'h100, 1'b1, 32'h110);

    // Saturate at max, then two not-taken bring the counter to 1.
    for (int i = 0; i < 3; i++)
      issue(mk(BEQ, 32'd5, 32'd5, 32'h100, 13'h010, 1'b1, 32'h110, 1'b1, 32'h110, 1'b0));
    issue(mk(BEQ, 32'd5, 32'd6, 32'h100, 13'h010, 1'b1, 32'h110, 1'b0, 32'h104, 1'b1));
    issue(mk(BEQ, 32'd5, 32'd6, 32'h100, 13'h010, 1'b1, 32'h110, 1'b0, 32'h104, 1'b1));
    look("ctr 2 0x100", 32'h100, 1'b1, 32'h110);
    idle();
    look("ctr 1 0x100", 32'h100, 1'b0, 32'h104);

    // Alias at the same index replaces the entry.
    issue(mk(BEQ, 32'd1, 32'd1, 32'h140, 13'h020, 1'b0, 32'h0, 1'b1, 32'h160, 1'b1));
    idle();
    look("aliased 0x100", 32'h100, 1'b0, 32'h104);
    look("alias 0x140", 32'h140, 1'b1, 32'h160);
    idle();
    check("hold out_valid", {31'd0, out_valid}, 32'd0);
    check("hold branch_taken", {31'd0, branch_taken}, 32'd1);
    check("hold branch_addr", branch_addr, 32'h160);
    check("hold mispredict", {31'd0, mispredict}, 32'd1);

    // Miss and not taken leaves the entry alone.
    issue(mk(BNE, 32'd2, 32'd2, 32'h180, 13'h020, 1'b0, 32'h0, 1'b0, 32'h184, 1'b0));
    idle();
    look("kept 0x140", 32'h140, 1'b1, 32'h160);
    look("no alloc 0x180", 32'h180, 1'b0, 32'h184);

    // Reset together with a taken resolution: discarded, table cleared.
    @(negedge CLK);
    RST = 1'b1; res_valid = 1'b1; branch_type = BEQ; rs1_data = 32'd4; rs2_data = 32'd4;
    res_pc = 32'h240; imm_sb = 13'h010; res_pred_taken = 1'b0;
    @(negedge CLK);
    check("rst+res out_valid", {31'd0, out_valid}, 32'd0);
    check("rst+res branch_addr", branch_addr, 32'd0);
    RST = 1'b0; res_valid = 1'b0;
    look("cleared 0x140", 32'h140, 1'b0, 32'h144);
    look("ignored 0x240", 32'h240, 1'b0, 32'h244);
    @(negedge CLK);
    check("post-rst out_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge CLK);
    check("scoreboard drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
